// File: rtl/cr_update_ctrl.sv
// cr_update_ctrl: arbitrates four condition-register update sources onto a
// single registered 32-bit CR (bit 0 = MSB, field n = bits 4n..4n+3).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmp_req/bf/val, cmp_gnt  compare result written to field cmp_bf
//   cr0_req/val, cr0_gnt     record-form write of field 0
//   bit_req/bt/val, bit_gnt  single bit write
//   mov_req/bf/bfa, mov_gnt  field copy (mcrf), field bfa -> field bf
//   mtcr_we, mtcr_din        full overwrite, beats all requesters and freeze
//   freeze                   stall: withholds all grants
//   CR                       registered condition register
//   busy                     some request is high and not granted this cycle
//
// Grants are combinational; CR takes the update at the next rising edge.
// Round-robin order is cmp, cr0, bit, mov starting at rr_ptr_q.
module cr_update_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmp_req,
  input  logic [2:0]  cmp_bf,
  input  logic [3:0]  cmp_val,
  output logic        cmp_gnt,
  input  logic        cr0_req,
  input  logic [3:0]  cr0_val,
  output logic        cr0_gnt,
  input  logic        bit_req,
  input  logic [4:0]  bit_bt,
  input  logic        bit_val,
  output logic        bit_gnt,
  input  logic        mov_req,
  input  logic [2:0]  mov_bf,
  input  logic [2:0]  mov_bfa,
  output logic        mov_gnt,
  input  logic        mtcr_we,
  input  logic [31:0] mtcr_din,
  input  logic        freeze,
  output logic [31:0] CR,
  output logic        busy
);

  logic [31:0] cr_q, cr_d;
  logic [1:0]  rr_ptr_q;

  logic [3:0]  req, gnt;
  logic [1:0]  gnt_idx, cand;
  logic        any_gnt, arb_en;

  // Bit positions in the little-endian vector: field n's MSB (LT) sits at 31-4n.
  logic [4:0]  cmp_sh, mov_dst_sh, mov_src_sh, bit_sh;
  logic [31:0] mov_src;

  assign cmp_sh     = 5'd28 - {cmp_bf, 2'b00};
  assign mov_dst_sh = 5'd28 - {mov_bf, 2'b00};
  assign mov_src_sh = 5'd28 - {mov_bfa, 2'b00};
  assign bit_sh     = 5'd31 - bit_bt;
  assign mov_src    = (cr_q >> mov_src_sh) & 32'hF;

  // Round-robin pick starting at rr_ptr_q; index 0 = cmp ... 3 = mov.
  always_comb begin
    req     = {mov_req, bit_req, cr0_req, cmp_req};
    gnt     = '0;
    gnt_idx = rr_ptr_q;
    any_gnt = 1'b0;
    cand    = '0;
    arb_en  = !rst && !freeze && !mtcr_we;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (arb_en && !any_gnt && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        any_gnt   = 1'b1;
      end
    end
  end

  always_comb begin
    cr_d = cr_q;
    unique case (gnt)
      4'b0001: cr_d = (cr_q & ~(32'hF << cmp_sh)) | ({28'b0, cmp_val} << cmp_sh);
      4'b0010: cr_d = {cr0_val, cr_q[27:0]};
      4'b0100: cr_d = (cr_q & ~(32'h1 << bit_sh)) | ({31'b0, bit_val} << bit_sh);
      // Same source and destination field writes the field back unchanged.
      4'b1000: cr_d = (cr_q & ~(32'hF << mov_dst_sh)) | (mov_src << mov_dst_sh);
      default: cr_d = cr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_q     <= 32'h0000_0000;
      rr_ptr_q <= 2'd0;
    end else if (mtcr_we) begin
      cr_q     <= mtcr_din;
    end else begin
      cr_q <= cr_d;
      if (any_gnt) begin
        rr_ptr_q <= gnt_idx + 2'd1;
      end
    end
  end

  assign cmp_gnt = gnt[0];
  assign cr0_gnt = gnt[1];
  assign bit_gnt = gnt[2];
  assign mov_gnt = gnt[3];
  assign CR      = cr_q;
  // Busy whenever a raised request is left waiting, even if another was granted.
  assign busy    = !rst && |(req & ~gnt);

endmodule
